// File: rtl/sipo_lsb_deserializer.sv
// sipo_lsb_deserializer
// Serial-in/parallel-out receiver that sits directly behind the LSB-first PISO
// shifter. One bit is taken per shift strobe; after WORD_LENGTH strobes the
// reassembled word is offered to the parallel consumer through a one-entry
// holding register with a valid/ready handshake. Words that complete while the
// holding register is still full and not being drained are dropped, and the
// sticky overflow flag records that this happened.
module sipo_lsb_deserializer #(
   parameter int WORD_LENGTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   serialInput,
   input  logic                   shift,
   input  logic                   clear,
   output logic [WORD_LENGTH-1:0] dataOut,
   output logic                   dataValid,
   input  logic                   dataReady,
   output logic                   busy,
   output logic                   overflow
);

   localparam int COUNT_WIDTH = $clog2(WORD_LENGTH);
   localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(WORD_LENGTH - 1);

   typedef enum logic {
      IDLE,
      COLLECT
   } stateType;

   stateType                 state;
   stateType                 nextState;
   logic [WORD_LENGTH-1:0]   shiftReg;
   logic [COUNT_WIDTH-1:0]   bitCount;
   logic [WORD_LENGTH-1:0]   completedWord;
   logic                     lastStrobe;
   logic                     wordDone;
   logic                     consume;

   // The word as it will look once the current strobe's bit is shifted in at
   // the top. Only meaningful on the completing strobe, where it is captured
   // straight into the holding register so the word appears one clock after
   // the last strobe rather than two.
   always_comb begin
      completedWord = {serialInput, shiftReg[WORD_LENGTH-1:1]};
      lastStrobe    = shift && (bitCount == LAST_COUNT);
      wordDone      = lastStrobe && !clear;
      consume       = dataValid && dataReady;
   end

   // State register for the collect/idle tracker. Reset always lands in IDLE
   // regardless of what else is being requested that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode. A first strobe starts a word (it can never also
   // finish one because words are at least two bits long). While collecting,
   // either the completing strobe or an abort via clear returns us to IDLE.
   always_comb begin
      nextState = state;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (shift && !clear) begin
               nextState = COLLECT;
            end
         end
         COLLECT: begin
            busy = 1'b1;
            if (clear || lastStrobe) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Bit assembly path. clear wins over a strobe in the same cycle and throws
   // that bit away along with any partial word. On the completing strobe the
   // counter wraps to zero and the shift register is left holding the full
   // word, which is harmless because the next word overwrites it bit by bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         shiftReg <= '0;
         bitCount <= '0;
      end else if (clear) begin
         shiftReg <= '0;
         bitCount <= '0;
      end else if (shift) begin
         shiftReg <= completedWord;
         if (lastStrobe) begin
            bitCount <= '0;
         end else begin
            bitCount <= bitCount + 1'b1;
         end
      end
   end

   // Holding register and handshake. A finished word is accepted when the
   // register is empty or is being drained on this very edge; otherwise it is
   // dropped and overflow latches until clear or reset. clear leaves the
   // holding register alone so a pending word survives an abort, and the
   // consumer can still drain it in the same cycle. dataOut is never zeroed
   // on consumption so the last word stays visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         dataOut   <= '0;
         dataValid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (wordDone) begin
            if (!dataValid || dataReady) begin
               dataOut   <= completedWord;
               dataValid <= 1'b1;
            end else begin
               overflow  <= 1'b1;
            end
         end else if (consume) begin
            dataValid <= 1'b0;
         end
         if (clear) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sipo_lsb_deserializer.sv
// tb_sipo_lsb_deserializer
// Bench for the LSB-first deserializer. A behavioural model tracks the bits
// received so far as a plain integer accumulator and the holding register as
// a value/valid/overflow triple; each scenario task drives stimulus and
// compares the DUT outputs against constants or that model.
module tb_sipo_lsb_deserializer;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         serialInput;
   logic         shift;
   logic         clear;
   logic [W-1:0] dataOut;
   logic         dataValid;
   logic         dataReady;
   logic         busy;
   logic         overflow;

   int checkCount = 0;
   int passCount  = 0;

   // Reference model state
   int           mCount;
   int unsigned  mAcc;
   logic [W-1:0] mData;
   logic         mValid;
   logic         mOvf;

   sipo_lsb_deserializer #(.WORD_LENGTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .serialInput (serialInput),
      .shift       (shift),
      .clear       (clear),
      .dataOut     (dataOut),
      .dataValid   (dataValid),
      .dataReady   (dataReady),
      .busy        (busy),
      .overflow    (overflow)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Puts the model back to its post-reset contents
   task automatic resetModel();
      mCount = 0;
      mAcc   = 0;
      mData  = '0;
      mValid = 1'b0;
      mOvf   = 1'b0;
   endtask

   // Drives one clock of inputs on the falling edge, advances the model on the
   // rising edge, and returns 1 time unit later so outputs can be sampled
   task automatic applyStimulus(input logic s, input logic b, input logic c, input logic r);
      logic consume;
      @(negedge clk);
      shift       = s;
      serialInput = b;
      clear       = c;
      dataReady   = r;
      @(posedge clk);
      consume = mValid && r;
      if (c) begin
         mCount = 0;
         mAcc   = 0;
         mOvf   = 1'b0;
         if (consume) mValid = 1'b0;
      end else if (s) begin
         mAcc   = mAcc | (int'(b) << mCount);
         mCount = mCount + 1;
         if (mCount == W) begin
            if (!mValid || r) begin
               mData  = W'(mAcc);
               mValid = 1'b1;
            end else begin
               mOvf = 1'b1;
            end
            mCount = 0;
            mAcc   = 0;
         end else if (consume) begin
            mValid = 1'b0;
         end
      end else if (consume) begin
         mValid = 1'b0;
      end
      #1;
   endtask

   // Holds reset for one clock with every other input active to show reset wins
   task automatic doReset();
      @(negedge clk);
      rst         = 1'b1;
      shift       = 1'b1;
      serialInput = 1'b1;
      clear       = 1'b1;
      dataReady   = 1'b1;
      @(posedge clk);
      resetModel();
      #1;
      rst   = 1'b0;
      shift = 1'b0;
      clear = 1'b0;
   endtask

   // Sends a word LSB first; optional random idle gaps before each bit, and
   // dataReady can differ on the completing strobe
   task automatic sendWord(input logic [W-1:0] w, input logic rdy, input logic rdyLast, input int gapMax);
      logic [W-1:0] word;
      word = w;
      for (int i = 0; i < W; i++) begin
         if (gapMax > 0) begin
            int gaps;
            gaps = $urandom_range(gapMax, 0);
            for (int g = 0; g < gaps; g++) applyStimulus(1'b0, 1'b0, 1'b0, rdy);
         end
         applyStimulus(1'b1, word[i], 1'b0, (i == W - 1) ? rdyLast : rdy);
      end
   endtask

   task automatic test_reset();
      doReset();
      checkCount++;
      if (dataOut !== 8'h00) $display("[TB] FAIL reset_dataOut: got %h expected %h", dataOut, 8'h00);
      else passCount++;
      checkCount++;
      if ({dataValid, busy, overflow} !== 3'b000)
         $display("[TB] FAIL reset_flags: got valid/busy/ovf=%b expected 000", {dataValid, busy, overflow});
      else passCount++;
   endtask

   task automatic test_basic();
      logic [W-1:0] bits;
      bits = 8'b1010_0101;
      for (int i = 0; i < W; i++) begin
         applyStimulus(1'b1, bits[i], 1'b0, 1'b0);
         if (i == 3) begin
            checkCount++;
            if (busy !== 1'b1) $display("[TB] FAIL basic_busy_mid: got %b expected 1", busy);
            else passCount++;
         end
      end
      checkCount++;
      if (dataOut !== 8'hA5) $display("[TB] FAIL basic_dataOut: got %h expected %h", dataOut, 8'hA5);
      else passCount++;
      checkCount++;
      if ({dataValid, busy} !== 2'b10) $display("[TB] FAIL basic_valid_busy: got %b expected 10", {dataValid, busy});
      else passCount++;
   endtask

   task automatic test_loopback();
      for (int pass = 0; pass < 2; pass++) begin
         logic [W-1:0] piso;
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         piso = 8'h3C;
         for (int i = 0; i < W; i++) begin
            if (pass == 1) begin
               int gaps;
               gaps = $urandom_range(3, 0);
               for (int g = 0; g < gaps; g++) applyStimulus(1'b0, $urandom_range(1, 0) == 1, 1'b0, 1'b0);
            end
            applyStimulus(1'b1, piso[0], 1'b0, 1'b0);
            piso = piso >> 1;
         end
         checkCount++;
         if (dataOut !== 8'h3C || dataValid !== 1'b1)
            $display("[TB] FAIL loopback_pass%0d: got %h valid %b expected 3c valid 1", pass, dataOut, dataValid);
         else passCount++;
      end
   endtask

   task automatic test_overflow();
      doReset();
      sendWord(8'h11, 1'b0, 1'b0, 0);
      sendWord(8'h22, 1'b0, 1'b0, 0);
      checkCount++;
      if (dataOut !== 8'h11 || overflow !== 1'b1)
         $display("[TB] FAIL overflow_set: got data %h ovf %b expected 11 ovf 1", dataOut, overflow);
      else passCount++;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkCount++;
      if (overflow !== 1'b0 || dataValid !== 1'b1 || dataOut !== 8'h11)
         $display("[TB] FAIL overflow_clear: got ovf %b valid %b data %h expected 0 1 11", overflow, dataValid, dataOut);
      else passCount++;
   endtask

   task automatic test_consume_race();
      sendWord(8'h22, 1'b0, 1'b1, 0);
      checkCount++;
      if (dataOut !== 8'h22 || dataValid !== 1'b1 || overflow !== 1'b0)
         $display("[TB] FAIL consume_race: got data %h valid %b ovf %b expected 22 1 0", dataOut, dataValid, overflow);
      else passCount++;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkCount++;
      if (dataValid !== 1'b0 || dataOut !== 8'h22)
         $display("[TB] FAIL consume_drain: got valid %b data %h expected 0 22", dataValid, dataOut);
      else passCount++;
   endtask

   task automatic test_abort();
      logic [W-1:0] w;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkCount++;
      if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy);
      else passCount++;
      sendWord(8'hF0, 1'b0, 1'b0, 0);
      checkCount++;
      if (dataOut !== 8'hF0 || dataValid !== 1'b1)
         $display("[TB] FAIL abort_word: got %h valid %b expected f0 1", dataOut, dataValid);
      else passCount++;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      doReset();
      checkCount++;
      if (dataOut !== 8'h00 || {dataValid, busy, overflow} !== 3'b000)
         $display("[TB] FAIL midword_reset: got data %h flags %b expected 00 000", dataOut, {dataValid, busy, overflow});
      else passCount++;
      w = W'($urandom);
      sendWord(w, 1'b0, 1'b0, 2);
      checkCount++;
      if (dataOut !== w || dataValid !== 1'b1)
         $display("[TB] FAIL post_reset_word: got %h valid %b expected %h 1", dataOut, dataValid, w);
      else passCount++;
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      doReset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         logic s, b, c, r;
         s = ($urandom_range(3, 0) != 0);
         b = $urandom_range(1, 0) == 1;
         c = ($urandom_range(39, 0) == 0);
         r = ($urandom_range(2, 0) == 0);
         applyStimulus(s, b, c, r);
         checkCount++;
         if (dataOut !== mData || dataValid !== mValid || overflow !== mOvf || busy !== (mCount != 0)) begin
            if (errs < 10)
               $display("[TB] FAIL random_cycle%0d: got data %h v %b o %b b %b expected %h %b %b %b",
                        cyc, dataOut, dataValid, overflow, busy, mData, mValid, mOvf, mCount != 0);
            errs++;
         end else passCount++;
      end
   endtask

   // Scenario sequence
   initial begin
      rst         = 1'b0;
      serialInput = 1'b0;
      shift       = 1'b0;
      clear       = 1'b0;
      dataReady   = 1'b0;
      resetModel();
      test_reset();
      test_basic();
      test_loopback();
      test_overflow();
      test_consume_race();
      test_abort();
      test_random();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
